umi_regfile: RTL and testbench
==============================

Name: umi_regfile

Overview:
- Parametrised register-file target that sits behind umi_regif on its reg_* interface. Replaces the flat behavioural register array currently used in regfile benches.
- Adds:
  - programmable response latency via a ready handshake
  - address-decode, read-only and privilege errors on reg_err
  - a hardware-side update channel for status registers
  - a flattened register output for downstream logic

Parameters:
- AW, 64, reg_addr width (byte address)
- RW, 32, register width in bits; power of two, >=8
- REGS, 512, number of registers; power of two, >=2
- LATENCY, 1, cycles from request to reg_ready; >=1
- RO_MASK, {REGS{1'b0}}, bit i=1: register i is read-only from the bus
- PRIV_MASK, {REGS{1'b0}}, bit i=1: register i needs reg_prot[0]=1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- reg_write  in  1  write request, held until reg_ready
- reg_read  in  1  read request, held until reg_ready
- reg_addr  in  AW  byte address, held with request
- reg_wrdata  in  RW  write data, held with request
- reg_prot  in  2  [0]=privileged, [1]=unused
- reg_rddata  out  RW  read data, valid while reg_ready=1
- reg_ready  out  1  one-cycle completion pulse
- reg_err  out  2  response code, valid while reg_ready=1
- hw_we  in  1  hardware write strobe
- hw_addr  in  log2(REGS)  hardware write register index
- hw_wdata  in  RW  hardware write data
- regs_out  out  REGS*RW  flattened contents; register i at [i*RW +: RW]
- parity_err  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all registers = 0, reg_ready = 0, reg_err = 0, reg_rddata = 0, parity_err = 0, FSM = IDLE, latency counter = 0.
- Address decode:
  - idx = reg_addr[A +: log2(REGS)], where A = log2(RW/8).
  - Out of range if any reg_addr bit above A+log2(REGS)-1 is set.
  - Low A bits are ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If reg_read|reg_write is high, latch the kind, idx, wrdata and prot.
  - Load cnt = LATENCY-1.
  - Go to RESP if LATENCY=1, else go to WAIT.
- WAIT: decrement cnt each cycle; when cnt reaches 1, go to RESP.
- RESP:
  - reg_ready = 1 for exactly one cycle; then return to IDLE.
  - All outputs are registered. A request first seen in IDLE at cycle T completes with reg_ready high in cycle T+LATENCY.
  - The requester drops its request after sampling reg_ready. The block samples a new request in IDLE at T+LATENCY+1 at the earliest.
- Error priority (highest first):
  - both reg_read and reg_write high -> 2'b10, no update
  - out of range -> 2'b11
  - PRIV_MASK[idx]=1 and prot[0]=0 -> 2'b10
  - write with RO_MASK[idx]=1 -> 2'b10
  - otherwise 2'b00
- Write commit: the register updates on the clock edge that enters RESP, only when the error code is 00.
- Read data:
  - Sampled from the array on the edge entering RESP.
  - reg_rddata = 0 on any error and for writes.
  - reg_rddata returns to 0 after RESP.
- hw channel:
  - hw_we writes hw_wdata into hw_addr every cycle, ignoring RO_MASK and PRIV_MASK.
  - If a bus commit and hw_we target the same idx in the same cycle, the bus write wins.
  - A hw write to the register being read is visible if it lands at or before the sampling edge (read-after-write through the array, no bypass).
- regs_out reflects array contents with no added latency.
- Request signals changing during WAIT are ignored; latched values are used.
- Reset mid-operation: FSM to IDLE; a pending write is dropped unless already committed; no reg_ready is issued for the aborted request.

Optional Feature:
- Macro: UMI_REGFILE_PARITY_EN.
- When defined:
  - Each register stores an even-parity bit, updated on every bus or hw write; reset parity = 0.
  - A read whose stored parity mismatches returns reg_err = 2'b10 and still returns the data.
  - parity_err sets, and stays set until reset.
  - Parity bits are reachable by hierarchical force for error injection.
- When undefined: no parity storage; parity_err is tied 0.

Test Plan:
- LATENCY=1: write 0xDEADBEEF to addr 0x10, then read 0x10 -> reg_ready one cycle after each request; err=00; rddata=0xDEADBEEF; regs_out[4*32+:32]=0xDEADBEEF.
- LATENCY=4: read addr 0x0 at cycle T -> reg_ready exactly at T+4, single cycle; reg_err=00; rddata=0.
- REGS=512, RW=32: read addr 0x800 -> err=11, rddata=0. Write to RO_MASK[3] register (addr 0xC) -> err=10, value unchanged. Privileged register accessed with prot=00 -> err=10.
- Bus write 0x1 and hw_we with 0x2 to index 5 in the same commit cycle -> register 5 = 0x1. hw-only write of 0x2 -> reads back 0x2.
- Assert reset during WAIT of a write of 0x55 (LATENCY=3) -> no reg_ready; target register remains 0; next request completes normally.
- UMI_REGFILE_PARITY_EN: write 0xA5, force-flip its parity bit, read -> err=10, rddata=0xA5, parity_err=1 until reset.

Source files
------------

// File: rtl/umi_regfile.sv
// umi_regfile: register-file target for the umi_regif reg_* interface.
// Bus requests are held until a one-cycle reg_ready pulse that arrives LATENCY
// cycles after the request is first seen. The response carries an error code
// for address-decode, privilege and read-only violations. A hardware update
// channel (hw_*) writes registers directly. The whole array is also presented
// flattened on regs_out.
// Optional feature: define UMI_REGFILE_PARITY_EN to add per-register even
// parity. A read that finds bad parity reports 2'b10 and still returns the
// data, and it sets the sticky parity_err flag.
//
// Handshake: reg_read/reg_write (with reg_addr, reg_wrdata, reg_prot) are
// sampled only in IDLE. The requester holds them until it sees reg_ready=1 for
// one cycle, then drops them. reg_err and reg_rddata are valid only while
// reg_ready=1, and are zero otherwise.
module umi_regfile #(
  parameter int              AW        = 64,
  parameter int              RW        = 32,
  parameter int              REGS      = 512,
  parameter int              LATENCY   = 1,
  parameter logic [REGS-1:0] RO_MASK   = {REGS{1'b0}},
  parameter logic [REGS-1:0] PRIV_MASK = {REGS{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_write,
  input  logic                     reg_read,
  input  logic [AW-1:0]            reg_addr,
  input  logic [RW-1:0]            reg_wrdata,
  input  logic [1:0]               reg_prot,
  output logic [RW-1:0]            reg_rddata,
  output logic                     reg_ready,
  output logic [1:0]               reg_err,
  input  logic                     hw_we,
  input  logic [$clog2(REGS)-1:0]  hw_addr,
  input  logic [RW-1:0]            hw_wdata,
  output logic [REGS*RW-1:0]       regs_out,
  output logic                     parity_err
);

  localparam int IW = $clog2(REGS);
  localparam int A  = $clog2(RW / 8);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rd_q;
  logic            wr_q;
  logic            prot_q;
  logic            oor_q;
  logic [IW-1:0]   idx_q;
  logic [RW-1:0]   wdata_q;

  logic [RW-1:0]   mem [0:REGS-1];

  logic            in_idle;
  logic            req;
  logic [IW-1:0]   live_idx;
  logic            live_oor;
  logic            cur_rd;
  logic            cur_wr;
  logic            cur_prot;
  logic            cur_oor;
  logic [IW-1:0]   cur_idx;
  logic [RW-1:0]   cur_wdata;
  logic            enter_resp;
  logic [1:0]      err_base;
  logic [1:0]      err_final;
  logic            bus_commit;
  logic            rd_ok;
  logic [RW-1:0]   rd_word;

  // Bits of the request that carry no meaning here.
  logic            unused_ok;
  assign unused_ok = ^{reg_prot[1], reg_addr};

  // Address decode of the live request. The low A bits are byte offsets
  // within a register and are ignored.
  assign req      = reg_read | reg_write;
  assign live_idx = reg_addr[A +: IW];
  assign live_oor = |(reg_addr >> (A + IW));
  assign in_idle  = (state == IDLE);

  // With LATENCY=1 the commit edge is the same edge that first sees the
  // request, so the live inputs are used. Otherwise the latched copy is used.
  assign cur_rd    = in_idle ? reg_read    : rd_q;
  assign cur_wr    = in_idle ? reg_write   : wr_q;
  assign cur_prot  = in_idle ? reg_prot[0] : prot_q;
  assign cur_oor   = in_idle ? live_oor    : oor_q;
  assign cur_idx   = in_idle ? live_idx    : idx_q;
  assign cur_wdata = in_idle ? reg_wrdata  : wdata_q;

  assign enter_resp = (in_idle && req && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt == CW'(1)));

  // Prioritised error code for the request about to complete.
  always_comb begin
    err_base = 2'b00;
    if (cur_rd && cur_wr)
      err_base = 2'b10;
    else if (cur_oor)
      err_base = 2'b11;
    else if (PRIV_MASK[cur_idx] && !cur_prot)
      err_base = 2'b10;
    else if (cur_wr && RO_MASK[cur_idx])
      err_base = 2'b10;
  end

  assign bus_commit = enter_resp && cur_wr && !cur_rd && (err_base == 2'b00);
  assign rd_ok      = enter_resp && cur_rd && !cur_wr && (err_base == 2'b00);
  assign rd_word    = mem[cur_idx];

`ifdef UMI_REGFILE_PARITY_EN
  logic [REGS-1:0] par_q;
  logic            par_err_q;
  logic            par_bad;

  assign par_bad    = (^rd_word) != par_q[cur_idx];
  assign err_final  = (rd_ok && par_bad) ? 2'b10 : err_base;
  assign parity_err = par_err_q;

  // Parity shadow follows every array write, and the bus write wins a collision.
  // parity_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      if (hw_we)
        par_q[hw_addr] <= ^hw_wdata;
      if (bus_commit)
        par_q[cur_idx] <= ^cur_wdata;
      if (rd_ok && par_bad)
        par_err_q <= 1'b1;
    end
  end
`else
  assign err_final  = err_base;
  assign parity_err = 1'b0;
`endif

  // Register array: the hw channel writes every cycle, and a bus commit to the
  // same index overrides it because it is assigned later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++)
        mem[i] <= '0;
    end else begin
      if (hw_we)
        mem[hw_addr] <= hw_wdata;
      if (bus_commit)
        mem[cur_idx] <= cur_wdata;
    end
  end

  // The flattened view tracks the array directly.
  for (genvar gi = 0; gi < REGS; gi++) begin : g_out
    assign regs_out[gi*RW +: RW] = mem[gi];
  end

  // Request FSM with registered response outputs. A reset in the middle of a
  // request drops it without a reg_ready pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      prot_q     <= 1'b0;
      oor_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      reg_ready  <= 1'b0;
      reg_err    <= 2'b00;
      reg_rddata <= '0;
    end else begin
      reg_ready  <= 1'b0;
      reg_err    <= 2'b00;
      reg_rddata <= '0;
      if (enter_resp) begin
        reg_ready  <= 1'b1;
        reg_err    <= err_final;
        reg_rddata <= rd_ok ? rd_word : '0;
      end
      case (state)
        IDLE: begin
          if (req) begin
            rd_q    <= reg_read;
            wr_q    <= reg_write;
            prot_q  <= reg_prot[0];
            oor_q   <= live_oor;
            idx_q   <= live_idx;
            wdata_q <= reg_wrdata;
            cnt     <= CW'(LATENCY - 1);
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umi_regfile.sv
// Directed bench for umi_regfile. It uses three instances that share the clock
// and reset:
//   u0: LATENCY=1, register 3 read-only, register 6 privileged
//   u1: LATENCY=4
//   u2: LATENCY=3 (reset during WAIT)
module tb_umi_regfile;

  localparam int REGS = 512;
  localparam int RW   = 32;

  logic clk;
  logic reset;

  logic                 wr     [3];
  logic                 rd     [3];
  logic [63:0]          addr   [3];
  logic [RW-1:0]        wdata  [3];
  logic [1:0]           prot   [3];
  logic [RW-1:0]        rdat   [3];
  logic                 rdy    [3];
  logic [1:0]           errv   [3];
  logic                 hwe    [3];
  logic [8:0]           hwa    [3];
  logic [RW-1:0]        hwd    [3];
  logic [REGS*RW-1:0]   regs   [3];
  logic                 perr   [3];

  int n_checks;
  int n_pass;

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  umi_regfile #(.LATENCY(1), .RO_MASK(512'h8), .PRIV_MASK(512'h40)) u0 (
    .clk(clk), .reset(reset), .reg_write(wr[0]), .reg_read(rd[0]),
    .reg_addr(addr[0]), .reg_wrdata(wdata[0]), .reg_prot(prot[0]),
    .reg_rddata(rdat[0]), .reg_ready(rdy[0]), .reg_err(errv[0]),
    .hw_we(hwe[0]), .hw_addr(hwa[0]), .hw_wdata(hwd[0]),
    .regs_out(regs[0]), .parity_err(perr[0]));

  umi_regfile #(.LATENCY(4)) u1 (
    .clk(clk), .reset(reset), .reg_write(wr[1]), .reg_read(rd[1]),
    .reg_addr(addr[1]), .reg_wrdata(wdata[1]), .reg_prot(prot[1]),
    .reg_rddata(rdat[1]), .reg_ready(rdy[1]), .reg_err(errv[1]),
    .hw_we(hwe[1]), .hw_addr(hwa[1]), .hw_wdata(hwd[1]),
    .regs_out(regs[1]), .parity_err(perr[1]));

  umi_regfile #(.LATENCY(3)) u2 (
    .clk(clk), .reset(reset), .reg_write(wr[2]), .reg_read(rd[2]),
    .reg_addr(addr[2]), .reg_wrdata(wdata[2]), .reg_prot(prot[2]),
    .reg_rddata(rdat[2]), .reg_ready(rdy[2]), .reg_err(errv[2]),
    .hw_we(hwe[2]), .hw_addr(hwa[2]), .hw_wdata(hwd[2]),
    .regs_out(regs[2]), .parity_err(perr[2]));

  // Scoreboard check: every comparison goes through here.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] reg_of(input int u, input int idx);
    return regs[u][idx*RW +: RW];
  endfunction

  // Driver: issue one bus request, wait (bounded) for reg_ready, then drop the
  // request and confirm the pulse lasted one cycle. Called #1 after a posedge.
  task automatic bus_op(input int u, input logic w, input logic r,
                        input logic [63:0] a, input logic [RW-1:0] d,
                        input logic [1:0] p, output logic [RW-1:0] rd_o,
                        output logic [1:0] err_o, output int lat_o);
    int  cyc;
    bit  seen;
    wr[u] = w; rd[u] = r; addr[u] = a; wdata[u] = d; prot[u] = p;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy[u]) seen = 1;
    end
    rd_o  = rdat[u];
    err_o = errv[u];
    lat_o = seen ? cyc : -1;
    wr[u] = 1'b0; rd[u] = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse", {63'd0, rdy[u]}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [RW-1:0] rdv;
  logic [1:0]    ev;
  int            lat;
  int            rdy_cnt;
`ifdef UMI_REGFILE_PARITY_EN
  logic [REGS-1:0] pv;
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0; rd[i] = 0; addr[i] = '0; wdata[i] = '0; prot[i] = 2'b00;
      hwe[i] = 0; hwa[i] = '0; hwd[i] = '0;
    end
    do_reset();

    // Reset state.
    check("rst_ready",  {63'd0, rdy[0]}, 64'd0);
    check("rst_err",    {62'd0, errv[0]}, 64'd0);
    check("rst_rddata", {32'd0, rdat[0]}, 64'd0);
    check("rst_reg4",   {32'd0, reg_of(0, 4)}, 64'd0);
    check("rst_perr",   {63'd0, perr[0]}, 64'd0);

    // LATENCY=1 write then read.
    bus_op(0, 1, 0, 64'h10, 32'hDEADBEEF, 2'b01, rdv, ev, lat);
    check("wr_lat", lat, 1);
    check("wr_err", ev, 2'b00);
    check("wr_rddata", rdv, 0);
    check("wr_regs_out", reg_of(0, 4), 32'hDEADBEEF);
    bus_op(0, 0, 1, 64'h10, 0, 2'b01, rdv, ev, lat);
    check("rd_lat", lat, 1);
    check("rd_err", ev, 2'b00);
    check("rd_data", rdv, 32'hDEADBEEF);
    // Byte-offset bits are ignored.
    bus_op(0, 0, 1, 64'h13, 0, 2'b01, rdv, ev, lat);
    check("rd_lowbits", rdv, 32'hDEADBEEF);

    // LATENCY=4 read of register 0.
    bus_op(1, 0, 1, 64'h0, 0, 2'b00, rdv, ev, lat);
    check("lat4_lat", lat, 4);
    check("lat4_err", ev, 2'b00);
    check("lat4_data", rdv, 0);

    // Out of range.
    bus_op(0, 0, 1, 64'h800, 0, 2'b01, rdv, ev, lat);
    check("oor_err", ev, 2'b11);
    check("oor_data", rdv, 0);
    bus_op(0, 1, 0, 64'h1_0000_0010, 32'h77, 2'b01, rdv, ev, lat);
    check("oor_hi_err", ev, 2'b11);
    check("oor_hi_nowr", reg_of(0, 4), 32'hDEADBEEF);

    // Read-only register 3.
    bus_op(0, 1, 0, 64'hC, 32'h1234, 2'b01, rdv, ev, lat);
    check("ro_err", ev, 2'b10);
    check("ro_unchanged", reg_of(0, 3), 0);

    // Privileged register 6.
    bus_op(0, 1, 0, 64'h18, 32'h66, 2'b00, rdv, ev, lat);
    check("priv_wr_err", ev, 2'b10);
    check("priv_wr_nowr", reg_of(0, 6), 0);
    bus_op(0, 1, 0, 64'h18, 32'h66, 2'b01, rdv, ev, lat);
    check("priv_ok_err", ev, 2'b00);
    bus_op(0, 0, 1, 64'h18, 0, 2'b10, rdv, ev, lat);
    check("priv_rd_err", ev, 2'b10);
    check("priv_rd_data", rdv, 0);

    // Read and write together.
    bus_op(0, 1, 1, 64'h10, 32'h1111, 2'b01, rdv, ev, lat);
    check("both_err", ev, 2'b10);
    check("both_data", rdv, 0);
    check("both_nowr", reg_of(0, 4), 32'hDEADBEEF);

    // Bus write and hw write to register 5 on the same commit edge.
    wr[0] = 1; addr[0] = 64'h14; wdata[0] = 32'h1; prot[0] = 2'b01;
    hwe[0] = 1; hwa[0] = 9'd5; hwd[0] = 32'h2;
    @(posedge clk); #1;
    hwe[0] = 0;
    check("coll_ready", {63'd0, rdy[0]}, 64'd1);
    wr[0] = 0;
    @(posedge clk); #1;
    check("coll_reg5", reg_of(0, 5), 32'h1);
    bus_op(0, 0, 1, 64'h14, 0, 2'b01, rdv, ev, lat);
    check("coll_rd", rdv, 32'h1);

    // hw-only write, then read it back.
    hwe[0] = 1; hwa[0] = 9'd7; hwd[0] = 32'h2;
    @(posedge clk); #1;
    hwe[0] = 0;
    check("hw_regs_out", reg_of(0, 7), 32'h2);
    bus_op(0, 0, 1, 64'h1C, 0, 2'b01, rdv, ev, lat);
    check("hw_rd", rdv, 32'h2);
    check("hw_rd_err", ev, 2'b00);

    // Reset during WAIT of a LATENCY=3 write.
    wr[2] = 1; addr[2] = 64'h20; wdata[2] = 32'h55; prot[2] = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wr[2] = 0;
    rdy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rdy[2]) rdy_cnt++;
    end
    check("abort_no_ready", rdy_cnt, 0);
    check("abort_reg8", reg_of(2, 8), 0);
    check("abort_u0_cleared", reg_of(0, 4), 0);
    bus_op(2, 1, 0, 64'h20, 32'h55, 2'b00, rdv, ev, lat);
    check("after_abort_lat", lat, 3);
    check("after_abort_err", ev, 2'b00);
    check("after_abort_reg8", reg_of(2, 8), 32'h55);

`ifdef UMI_REGFILE_PARITY_EN
    // Parity error injection on register 9.
    bus_op(0, 1, 0, 64'h24, 32'hA5, 2'b01, rdv, ev, lat);
    check("par_wr_err", ev, 2'b00);
    bus_op(0, 0, 1, 64'h24, 0, 2'b01, rdv, ev, lat);
    check("par_clean_err", ev, 2'b00);
    check("par_clean_perr", {63'd0, perr[0]}, 64'd0);
    pv = u0.par_q;
    pv[9] = ~pv[9];
    force u0.par_q = pv;
    bus_op(0, 0, 1, 64'h24, 0, 2'b01, rdv, ev, lat);
    release u0.par_q;
    check("par_err", ev, 2'b10);
    check("par_data", rdv, 32'hA5);
    repeat (3) @(posedge clk);
    #1;
    check("par_sticky", {63'd0, perr[0]}, 64'd1);
    do_reset();
    check("par_cleared", {63'd0, perr[0]}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
